// File: rtl/posi_md_rd.sv
// Intra-mode reader for the pre-intra ping-pong buffer: maps (size, z-index) requests to buffer
// addresses, captures the one-cycle-latency read data and returns results in order via a FIFO.
module posi_md_rd #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MD_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_size_i,
    input  logic [7:0]          req_idx_i,
    input  logic                req_last_i,
    output logic                posi_md_ena_o,
    output logic [8:0]          posi_md_addr_o,
    input  logic [MD_WIDTH-1:0] posi_md_data_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [MD_WIDTH-1:0] rsp_mode_o,
    output logic                rsp_err_o,
    output logic                rsp_last_o
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned CNTW = CW + 1;
    localparam int unsigned EW   = MD_WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_err_q, pend_err_d;
    logic             pend_last_q, pend_last_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    fcnt_q, fcnt_d;

    logic             busy;
    logic             rsp_valid;
    logic             pop;
    logic             accept;
    logic             req_err;
    logic [8:0]       req_base;
    logic [8:0]       req_addr;
    logic [CNTW-1:0]  cnt_after;
    logic [EW-1:0]    head;

    assign busy        = (state_q != StIdle);
    assign rsp_valid   = (fcnt_q != '0);
    assign pop         = rsp_valid && rsp_ready_i;
    // Outstanding credits (pending + stored) after this cycle's pop.
    assign cnt_after   = CNTW'(fcnt_q) + CNTW'(pend_valid_q) - CNTW'(pop);
    assign req_ready_o = (state_q == StRun) && !start_i && (cnt_after < CNTW'(DEPTH));
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        req_base = 9'd0;
        req_err  = 1'b0;
        unique case (req_size_i)
            2'd3: begin req_base = 9'd0;  req_err = |req_idx_i[7:2]; end
            2'd2: begin req_base = 9'd4;  req_err = |req_idx_i[7:4]; end
            2'd1: begin req_base = 9'd20; req_err = |req_idx_i[7:6]; end
            default: begin req_base = 9'd84; req_err = 1'b0; end
        endcase
    end

    assign req_addr       = req_base + {1'b0, req_idx_i};
    assign posi_md_ena_o  = accept && !req_err;
    assign posi_md_addr_o = posi_md_ena_o ? req_addr : 9'd0;

    assign head        = mem_q[rd_ptr_q];
    assign rsp_valid_o = rsp_valid;
    assign rsp_mode_o  = rsp_valid ? head[EW-1:2] : '0;
    assign rsp_err_o   = rsp_valid && head[1];
    assign rsp_last_o  = rsp_valid && head[0];
    assign busy_o      = busy;
    assign done_o      = done_q;

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        pend_valid_d = 1'b0;
        pend_err_d   = 1'b0;
        pend_last_d  = 1'b0;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fcnt_d       = fcnt_q;

        if (start_i) begin
            // Restart drops everything in flight, including the pending RAM read.
            state_d  = StRun;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fcnt_d   = '0;
        end else begin
            pend_valid_d = accept;
            pend_err_d   = req_err;
            pend_last_d  = req_last_i;

            if (pend_valid_q) begin
                mem_d[wr_ptr_q] = {pend_err_q ? MD_WIDTH'(1) : posi_md_data_i,
                                   pend_err_q, pend_last_q};
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            fcnt_d = fcnt_q + CW'(pend_valid_q) - CW'(pop);

            unique case (state_q)
                StRun: begin
                    if (accept && req_last_i) state_d = StDrain;
                end
                StDrain: begin
                    if (pop && head[0]) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            done_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_err_q   <= 1'b0;
            pend_last_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fcnt_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            pend_valid_q <= pend_valid_d;
            pend_err_q   <= pend_err_d;
            pend_last_q  <= pend_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fcnt_q       <= fcnt_d;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_posi_md_rd.sv
// Self-checking bench for posi_md_rd: directed scenarios plus random traffic, all compared
// against a transaction-level model (outstanding-response queue and session flags).
module tb_posi_md_rd;

    localparam int DEPTH = 4;
    localparam int MDW   = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i, busy_o, done_o;
    logic           req_valid_i, req_ready_o, req_last_i;
    logic [1:0]     req_size_i;
    logic [7:0]     req_idx_i;
    logic           posi_md_ena_o;
    logic [8:0]     posi_md_addr_o;
    logic [MDW-1:0] posi_md_data_i;
    logic           rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_last_o;
    logic [MDW-1:0] rsp_mode_o;

    always #5 clk = ~clk;

    posi_md_rd #(.DEPTH(DEPTH), .MD_WIDTH(MDW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_size_i     (req_size_i),
        .req_idx_i      (req_idx_i),
        .req_last_i     (req_last_i),
        .posi_md_ena_o  (posi_md_ena_o),
        .posi_md_addr_o (posi_md_addr_o),
        .posi_md_data_i (posi_md_data_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_mode_o     (rsp_mode_o),
        .rsp_err_o      (rsp_err_o),
        .rsp_last_o     (rsp_last_o)
    );

    // Buffer model: one-cycle read latency, data = addr[5:0].
    logic [MDW-1:0] ram_q;
    always @(posedge clk or posedge rst) begin
        if (rst) ram_q <= '0;
        else if (posi_md_ena_o) ram_q <= posi_md_addr_o[5:0];
    end
    assign posi_md_data_i = ram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int mode;
        bit err;
        bit last;
        int t;
    } exp_t;

    exp_t exp_q[$];
    bit   m_busy, m_lt, m_done;
    int   n_err = 0;
    int   n_chk = 0;
    int   acc_cnt = 0;
    int   pop_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A 64x64 LCU holds 4^(4-s) blocks of size s; sizes are laid out largest first.
    function automatic int blocks(input int s);
        return 1 << (2 * (4 - s));
    endfunction

    function automatic int ref_addr(input int s, input int i);
        int base = 0;
        for (int k = 3; k > s; k--) base += blocks(k);
        return base + i;
    endfunction

    function automatic bit ref_err(input int s, input int i);
        return (s != 0) && (i >= blocks(s));
    endfunction

    task automatic step(input bit st, input bit v, input int sz, input int ix, input bit lst,
                        input bit rr);
        bit   exp_val, exp_rdy, pop, acc, e;
        int   a;
        exp_t h;
        @(negedge clk);
        start_i = st; req_valid_i = v; req_size_i = sz[1:0]; req_idx_i = ix[7:0];
        req_last_i = lst; rsp_ready_i = rr;
        #1;
        check_eq("done", 32'(done_o), 32'(m_done));
        m_done = 1'b0;
        check_eq("busy", 32'(busy_o), 32'(m_busy));
        exp_val = (exp_q.size() > 0) && (cyc >= exp_q[0].t + 2);
        pop     = exp_val && rr;
        exp_rdy = m_busy && !m_lt && !st && ((exp_q.size() - int'(pop)) < DEPTH);
        check_eq("rsp_valid", 32'(rsp_valid_o), 32'(exp_val));
        check_eq("req_ready", 32'(req_ready_o), 32'(exp_rdy));
        acc = v && exp_rdy;
        e   = ref_err(sz, ix);
        a   = ref_addr(sz, ix);
        check_eq("ena", 32'(posi_md_ena_o), 32'(acc && !e));
        if (acc && !e) check_eq("addr", 32'(posi_md_addr_o), a);
        if (exp_val) begin
            check_eq("rsp_mode", 32'(rsp_mode_o), exp_q[0].mode);
            check_eq("rsp_err", 32'(rsp_err_o), 32'(exp_q[0].err));
            check_eq("rsp_last", 32'(rsp_last_o), 32'(exp_q[0].last));
        end
        if (st) begin
            exp_q.delete();
            m_busy = 1'b1;
            m_lt   = 1'b0;
        end else begin
            if (pop) begin
                h = exp_q.pop_front();
                pop_cnt++;
                if (h.last) begin
                    m_busy = 1'b0;
                    m_lt   = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (acc) begin
                exp_q.push_back('{e ? 1 : (a & 63), e, lst, cyc});
                acc_cnt++;
                if (lst) m_lt = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, rr);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_o), 0);
        check_eq({tag, "_done"}, 32'(done_o), 0);
        check_eq({tag, "_ready"}, 32'(req_ready_o), 0);
        check_eq({tag, "_ena"}, 32'(posi_md_ena_o), 0);
        check_eq({tag, "_addr"}, 32'(posi_md_addr_o), 0);
        check_eq({tag, "_valid"}, 32'(rsp_valid_o), 0);
        check_eq({tag, "_mode"}, 32'(rsp_mode_o), 0);
        check_eq({tag, "_err"}, 32'(rsp_err_o), 0);
        check_eq({tag, "_last"}, 32'(rsp_last_o), 0);
    endtask

    initial begin
        int a0, p0, sz, ix;
        rst = 1'b1;
        start_i = 1'b0; req_valid_i = 1'b0; req_size_i = '0; req_idx_i = '0;
        req_last_i = 1'b0; rsp_ready_i = 1'b0;
        m_busy = 1'b0; m_lt = 1'b0; m_done = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Address mapping
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 3, 2, 1'b0, 1'b1);
        step(1'b0, 1'b1, 2, 15, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1, 0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 0, 255, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Range errors followed by a legal request
        step(1'b0, 1'b1, 3, 4, 1'b0, 1'b1);
        step(1'b0, 1'b1, 2, 16, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1, 5, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Backpressure: exactly DEPTH accepts while responses are stalled
        a0 = acc_cnt;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1, i, 1'b0, 1'b0);
        check_eq("bp_accepts", acc_cnt - a0, DEPTH);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2, i, 1'b0, 1'b1);
        idle(5, 1'b1);

        // Session end: 10 accepted requests, the last flagged
        a0 = acc_cnt;
        p0 = pop_cnt;
        for (int i = 0; i < 40 && (acc_cnt - a0) < 10; i++)
            step(1'b0, 1'b1, 0, 100 + i, (acc_cnt - a0) == 9, 1'b1);
        check_eq("sess_accepts", acc_cnt - a0, 10);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0, i, 1'b0, 1'b1);
        check_eq("sess_pops", pop_cnt - p0, 10);
        check_eq("sess_busy", 32'(busy_o), 0);

        // Restart mid-session
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1, 7 + i, 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b1, 1'b1, 1, 3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Async reset while draining with two stored entries
        step(1'b0, 1'b1, 2, 3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2, 4, 1'b1, 1'b0);
        idle(2, 1'b0);
        check_eq("pre_rst_valid", 32'(rsp_valid_o), 1);
        @(negedge clk);
        req_valid_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_all_zero("arst");
        exp_q.delete();
        m_busy = 1'b0; m_lt = 1'b0; m_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, i, 1'b0, 1'b1);

        // Random traffic
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            sz = int'($urandom_range(0, 3));
            ix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, blocks(sz) - 1));
            if (sz == 0) ix = int'($urandom_range(0, 255));
            step(($urandom_range(0, 59) == 0) || (!m_busy && $urandom_range(0, 3) == 0),
                 $urandom_range(0, 3) != 0, sz, ix, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0);
        end
        idle(12, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
